// File: rtl/flow_solver_seq.sv
// rtl/flow_solver_seq.sv - multi-cycle Lucas-Kanade 2x2 flow solver
//
// Solves [IxIx IxIy; IxIy IyIy] * [u v]' = [IxIt IyIt]' by Cramer's rule.
// The six products are kept at full width, and the determinant and
// numerators carry one extra bit, so nothing truncates before the divide.
// Quotient magnitudes for u and v come from two restoring dividers that
// share one shifted divisor and one bit counter.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   sum_*                            signed window sums from the accumulator
//   pixel_x_in, pixel_y_in           coordinate tag carried with the sums
//   in_valid / in_ready              input handshake (in_ready only in IDLE)
//   flow_u, flow_v                   signed fixed-point flow (FRAC_BITS frac)
//   flow_status                      00 ok, 01 clamped, 10 unsolvable
//   pixel_x_out, pixel_y_out         tag of the presented result
//   out_valid / out_ready            output handshake, held until accepted
module flow_solver_seq #(
    parameter int ACCUM_WIDTH   = 32,
    parameter int FLOW_WIDTH    = 16,
    parameter int FRAC_BITS     = 7,
    parameter int DET_THRESHOLD = 1000,
    parameter int MAX_FLOW      = 1024,
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IxIx,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IyIy,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IxIy,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IxIt,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IyIt,
    input  logic        [X_WIDTH-1:0]     pixel_x_in,
    input  logic        [Y_WIDTH-1:0]     pixel_y_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [FLOW_WIDTH-1:0]  flow_u,
    output logic signed [FLOW_WIDTH-1:0]  flow_v,
    output logic        [1:0]             flow_status,
    output logic        [X_WIDTH-1:0]     pixel_x_out,
    output logic        [Y_WIDTH-1:0]     pixel_y_out,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int PW = 2 * ACCUM_WIDTH;               // product width
    localparam int DW = PW + 1;                        // det / numerator width
    localparam int RW = DW + FLOW_WIDTH + FRAC_BITS;   // divider working width
    localparam int CW = $clog2(FLOW_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DET,
        S_DIV,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [ACCUM_WIDTH-1:0] ixix_q, ixix_d, iyiy_q, iyiy_d, ixiy_q, ixiy_d;
    logic signed [ACCUM_WIDTH-1:0] ixit_q, ixit_d, iyit_q, iyit_d;
    logic        [X_WIDTH-1:0]     px_q, px_d;
    logic        [Y_WIDTH-1:0]     py_q, py_d;
    logic signed [PW-1:0]          p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic signed [PW-1:0]          p3_q, p3_d, p4_q, p4_d, p5_q, p5_d;
    logic        [RW-1:0]          rem_u_q, rem_u_d, rem_v_q, rem_v_d, dsr_q, dsr_d;
    logic        [FLOW_WIDTH-1:0]  quo_u_q, quo_u_d, quo_v_q, quo_v_d;
    logic                          neg_u_q, neg_u_d, neg_v_q, neg_v_d;
    logic                          sat_u_q, sat_u_d, sat_v_q, sat_v_d;
    logic        [CW-1:0]          cnt_q, cnt_d;
    logic signed [FLOW_WIDTH-1:0]  flow_u_q, flow_u_d, flow_v_q, flow_v_d;
    logic        [1:0]             status_q, status_d;

    // Determinant stage, evaluated from the registered products.
    logic signed [DW-1:0] det, num_u, num_v;
    logic        [DW-1:0] det_mag, num_u_mag, num_v_mag;
    logic        [RW-1:0] dvd_u, dvd_v, det_lim;
    logic                 solvable;

    always_comb begin
        det       = DW'(p0_q) - DW'(p1_q);
        num_u     = DW'(p2_q) - DW'(p3_q);
        num_v     = DW'(p4_q) - DW'(p5_q);
        det_mag   = det[DW-1]   ? -det   : det;
        num_u_mag = num_u[DW-1] ? -num_u : num_u;
        num_v_mag = num_v[DW-1] ? -num_v : num_v;
        solvable  = det_mag > DW'(DET_THRESHOLD);
        dvd_u     = RW'(num_u_mag) << FRAC_BITS;
        dvd_v     = RW'(num_v_mag) << FRAC_BITS;
        // A quotient that would not fit in FLOW_WIDTH magnitude bits.
        det_lim   = RW'(det_mag) << FLOW_WIDTH;
    end

    // One restoring step per component; the divisor shift is shared.
    logic                  ge_u, ge_v;
    logic [FLOW_WIDTH-1:0] quo_u_nx, quo_v_nx;

    always_comb begin
        ge_u     = rem_u_q >= dsr_q;
        ge_v     = rem_v_q >= dsr_q;
        quo_u_nx = {quo_u_q[FLOW_WIDTH-2:0], ge_u};
        quo_v_nx = {quo_v_q[FLOW_WIDTH-2:0], ge_v};
    end

    // Returns {clamped, signed result}. Zero magnitude never gets a sign.
    function automatic logic [FLOW_WIDTH:0] finalize(
        input logic [FLOW_WIDTH-1:0] quo,
        input logic                  sat,
        input logic                  neg
    );
        logic [FLOW_WIDTH-1:0] mag;
        logic                  clamp;
        mag   = sat ? {FLOW_WIDTH{1'b1}} : quo;
        clamp = mag > FLOW_WIDTH'(MAX_FLOW);
        if (clamp) begin
            mag = FLOW_WIDTH'(MAX_FLOW);
        end
        if (neg && (mag != '0)) begin
            mag = ~mag + FLOW_WIDTH'(1);
        end
        return {clamp, mag};
    endfunction

    logic [FLOW_WIDTH:0] fin_u, fin_v;

    always_comb begin
        fin_u = finalize(quo_u_nx, sat_u_q, neg_u_q);
        fin_v = finalize(quo_v_nx, sat_v_q, neg_v_q);
    end

    always_comb begin
        state_d  = state_q;
        ixix_d   = ixix_q;
        iyiy_d   = iyiy_q;
        ixiy_d   = ixiy_q;
        ixit_d   = ixit_q;
        iyit_d   = iyit_q;
        px_d     = px_q;
        py_d     = py_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        p3_d     = p3_q;
        p4_d     = p4_q;
        p5_d     = p5_q;
        rem_u_d  = rem_u_q;
        rem_v_d  = rem_v_q;
        dsr_d    = dsr_q;
        quo_u_d  = quo_u_q;
        quo_v_d  = quo_v_q;
        neg_u_d  = neg_u_q;
        neg_v_d  = neg_v_q;
        sat_u_d  = sat_u_q;
        sat_v_d  = sat_v_q;
        cnt_d    = cnt_q;
        flow_u_d = flow_u_q;
        flow_v_d = flow_v_q;
        status_d = status_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ixix_d  = sum_IxIx;
                    iyiy_d  = sum_IyIy;
                    ixiy_d  = sum_IxIy;
                    ixit_d  = sum_IxIt;
                    iyit_d  = sum_IyIt;
                    px_d    = pixel_x_in;
                    py_d    = pixel_y_in;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                p0_d    = PW'(ixix_q) * PW'(iyiy_q);
                p1_d    = PW'(ixiy_q) * PW'(ixiy_q);
                p2_d    = PW'(iyiy_q) * PW'(ixit_q);
                p3_d    = PW'(ixiy_q) * PW'(iyit_q);
                p4_d    = PW'(ixix_q) * PW'(iyit_q);
                p5_d    = PW'(ixiy_q) * PW'(ixit_q);
                state_d = S_DET;
            end
            S_DET: begin
                if (!solvable) begin
                    flow_u_d = '0;
                    flow_v_d = '0;
                    status_d = 2'b10;
                    state_d  = S_OUT;
                end else begin
                    rem_u_d = dvd_u;
                    rem_v_d = dvd_v;
                    dsr_d   = RW'(det_mag) << (FLOW_WIDTH - 1);
                    quo_u_d = '0;
                    quo_v_d = '0;
                    neg_u_d = num_u[DW-1] ^ det[DW-1];
                    neg_v_d = num_v[DW-1] ^ det[DW-1];
                    sat_u_d = dvd_u >= det_lim;
                    sat_v_d = dvd_v >= det_lim;
                    cnt_d   = CW'(FLOW_WIDTH - 1);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_u_d = ge_u ? rem_u_q - dsr_q : rem_u_q;
                rem_v_d = ge_v ? rem_v_q - dsr_q : rem_v_q;
                dsr_d   = dsr_q >> 1;
                quo_u_d = quo_u_nx;
                quo_v_d = quo_v_nx;
                cnt_d   = cnt_q - CW'(1);
                // The last bit is folded straight into the output registers
                // so OUT begins exactly FLOW_WIDTH cycles after DIV.
                if (cnt_q == '0) begin
                    flow_u_d = fin_u[FLOW_WIDTH-1:0];
                    flow_v_d = fin_v[FLOW_WIDTH-1:0];
                    status_d = (fin_u[FLOW_WIDTH] || fin_v[FLOW_WIDTH]) ? 2'b01 : 2'b00;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ixix_q   <= '0;
            iyiy_q   <= '0;
            ixiy_q   <= '0;
            ixit_q   <= '0;
            iyit_q   <= '0;
            px_q     <= '0;
            py_q     <= '0;
            p0_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            p4_q     <= '0;
            p5_q     <= '0;
            rem_u_q  <= '0;
            rem_v_q  <= '0;
            dsr_q    <= '0;
            quo_u_q  <= '0;
            quo_v_q  <= '0;
            neg_u_q  <= 1'b0;
            neg_v_q  <= 1'b0;
            sat_u_q  <= 1'b0;
            sat_v_q  <= 1'b0;
            cnt_q    <= '0;
            flow_u_q <= '0;
            flow_v_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            ixix_q   <= ixix_d;
            iyiy_q   <= iyiy_d;
            ixiy_q   <= ixiy_d;
            ixit_q   <= ixit_d;
            iyit_q   <= iyit_d;
            px_q     <= px_d;
            py_q     <= py_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            p4_q     <= p4_d;
            p5_q     <= p5_d;
            rem_u_q  <= rem_u_d;
            rem_v_q  <= rem_v_d;
            dsr_q    <= dsr_d;
            quo_u_q  <= quo_u_d;
            quo_v_q  <= quo_v_d;
            neg_u_q  <= neg_u_d;
            neg_v_q  <= neg_v_d;
            sat_u_q  <= sat_u_d;
            sat_v_q  <= sat_v_d;
            cnt_q    <= cnt_d;
            flow_u_q <= flow_u_d;
            flow_v_q <= flow_v_d;
            status_q <= status_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign flow_u      = flow_u_q;
    assign flow_v      = flow_v_q;
    assign flow_status = status_q;
    assign pixel_x_out = px_q;
    assign pixel_y_out = py_q;

endmodule

// File: tb/tb_flow_solver_seq.sv
// tb/tb_flow_solver_seq.sv - self-checking bench for flow_solver_seq
module tb_flow_solver_seq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [31:0] sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt;
    logic        [9:0]  pixel_x_in;
    logic        [8:0]  pixel_y_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] flow_u, flow_v;
    logic        [1:0]  flow_status;
    logic        [9:0]  pixel_x_out;
    logic        [8:0]  pixel_y_out;
    logic               out_valid;
    logic               out_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    flow_solver_seq dut (
        .clk(clk), .rst_n(rst_n),
        .sum_IxIx(sum_IxIx), .sum_IyIy(sum_IyIy), .sum_IxIy(sum_IxIy),
        .sum_IxIt(sum_IxIt), .sum_IyIt(sum_IyIt),
        .pixel_x_in(pixel_x_in), .pixel_y_in(pixel_y_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .flow_u(flow_u), .flow_v(flow_v), .flow_status(flow_status),
        .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // Reference: Cramer's rule in wide integers, truncating division.
    task automatic model(input logic signed [31:0] a, d, b, c, e,
                         output logic signed [15:0] u, v,
                         output logic [1:0] st, output int lat);
        logic signed [127:0] ea, ed, eb, ec, ee, det, nu, nv, adet, mag;
        logic signed [127:0] n [2];
        logic signed [15:0]  r [2];
        logic                clamp;
        ea = a; ed = d; eb = b; ec = c; ee = e;
        det = ea * ed - eb * eb;
        nu  = ed * ec - eb * ee;
        nv  = ea * ee - eb * ec;
        adet = (det < 0) ? -det : det;
        if (adet <= 1000) begin
            u = 0; v = 0; st = 2'b10; lat = 2;
        end else begin
            n[0] = nu; n[1] = nv; clamp = 1'b0;
            for (int k = 0; k < 2; k++) begin
                mag = (((n[k] < 0) ? -n[k] : n[k]) * 128) / adet;
                if (mag > 1024) begin
                    mag = 1024; clamp = 1'b1;
                end
                if ((n[k] < 0) != (det < 0)) mag = -mag;
                r[k] = 16'(mag);
            end
            u = r[0]; v = r[1]; st = clamp ? 2'b01 : 2'b00; lat = 18;
        end
    endtask

    // Presents one transaction (entry and exit at #1 after a rising edge)
    // and returns what the DUT showed when out_valid rose.
    task automatic run_txn(input logic signed [31:0] a, d, b, c, e,
                           input logic [9:0] x, input logic [8:0] y,
                           output logic signed [15:0] u, v,
                           output logic [1:0] st, output logic [9:0] ox,
                           output logic [8:0] oy, output int lat);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        sum_IxIx = a; sum_IyIy = d; sum_IxIy = b; sum_IxIt = c; sum_IyIt = e;
        pixel_x_in = x; pixel_y_in = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        u = flow_u; v = flow_v; st = flow_status; ox = pixel_x_out; oy = pixel_y_out;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sum_IxIx = 0; sum_IyIy = 0; sum_IxIy = 0; sum_IxIt = 0; sum_IyIt = 0;
        pixel_x_in = 0; pixel_y_in = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, flow_u, flow_v, flow_status, pixel_x_out, pixel_y_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%0b u=%0d v=%0d st=%0d x=%0d y=%0d required all 0",
                     out_valid, flow_u, flow_v, flow_status, pixel_x_out, pixel_y_out);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed;
        logic signed [15:0] u, v;
        logic [1:0] st;
        logic [9:0] ox;
        logic [8:0] oy;
        int lat;
        run_txn(100, 100, 0, 200, -100, 10'd513, 9'd300, u, v, st, ox, oy, lat);
        checks++;
        if (u !== 16'sd256 || v !== -16'sd128 || st !== 2'b00) begin
            errors++;
            $display("FAIL basic_flow: got u=%0d v=%0d st=%0d required 256 -128 0", u, v, st);
        end
        checks++;
        if (lat !== 18 || ox !== 10'd513 || oy !== 9'd300) begin
            errors++;
            $display("FAIL basic_lat_tags: got lat=%0d x=%0d y=%0d required 18 513 300", lat, ox, oy);
        end
        run_txn(100000, 100000, 0, 50000, 0, 10'd1, 9'd2, u, v, st, ox, oy, lat);
        checks++;
        if (u !== 16'sd64 || v !== 16'sd0 || st !== 2'b00) begin
            errors++;
            $display("FAIL wide_det: got u=%0d v=%0d st=%0d required 64 0 0", u, v, st);
        end
        run_txn(100, 100, 0, 100000, 0, 10'd3, 9'd4, u, v, st, ox, oy, lat);
        checks++;
        if (u !== 16'sd1024 || v !== 16'sd0 || st !== 2'b01) begin
            errors++;
            $display("FAIL clamp_pos: got u=%0d v=%0d st=%0d required 1024 0 1", u, v, st);
        end
        run_txn(100, 100, 0, -1, 0, 10'd5, 9'd6, u, v, st, ox, oy, lat);
        checks++;
        if (u !== -16'sd1 || v !== 16'sd0 || st !== 2'b00) begin
            errors++;
            $display("FAIL trunc_neg: got u=%0d v=%0d st=%0d required -1 0 0", u, v, st);
        end
        run_txn(100, 100, 0, -100000, 0, 10'd7, 9'd8, u, v, st, ox, oy, lat);
        checks++;
        if (u !== -16'sd1024 || st !== 2'b01) begin
            errors++;
            $display("FAIL clamp_neg: got u=%0d st=%0d required -1024 1", u, st);
        end
    endtask

    task automatic test_threshold;
        logic signed [15:0] u, v;
        logic [1:0] st;
        logic [9:0] ox;
        logic [8:0] oy;
        int lat;
        run_txn(10, 10, 0, 50, 70, 10'd9, 9'd10, u, v, st, ox, oy, lat);
        checks++;
        if (u !== 0 || v !== 0 || st !== 2'b10 || lat !== 2) begin
            errors++;
            $display("FAIL det_100: got u=%0d v=%0d st=%0d lat=%0d required 0 0 2 2", u, v, st, lat);
        end
        run_txn(10, 100, 0, 5, 5, 10'd11, 9'd12, u, v, st, ox, oy, lat);
        checks++;
        if (st !== 2'b10 || lat !== 2) begin
            errors++;
            $display("FAIL det_1000: got st=%0d lat=%0d required 2 2", st, lat);
        end
        run_txn(7, 143, 0, 0, 0, 10'd13, 9'd14, u, v, st, ox, oy, lat);
        checks++;
        if (u !== 0 || v !== 0 || st !== 2'b00 || lat !== 18) begin
            errors++;
            $display("FAIL det_1001: got u=%0d v=%0d st=%0d lat=%0d required 0 0 0 18", u, v, st, lat);
        end
        // det = -1001, num_u negative: signs cancel, magnitude clamps.
        run_txn(1, -1001, 0, 1000, 0, 10'd15, 9'd16, u, v, st, ox, oy, lat);
        checks++;
        if (u !== 16'sd1024 || v !== 16'sd0 || st !== 2'b01) begin
            errors++;
            $display("FAIL det_neg: got u=%0d v=%0d st=%0d required 1024 0 1", u, v, st);
        end
    endtask

    task automatic test_backpressure;
        logic signed [15:0] u, v;
        logic [1:0] st;
        logic [9:0] ox;
        logic [8:0] oy;
        int lat, bad;
        out_ready = 1'b0;
        run_txn(100, 100, 0, 200, -100, 10'd777, 9'd444, u, v, st, ox, oy, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            sum_IxIx = 1; sum_IyIy = 1; sum_IxIt = 0; pixel_x_in = 10'd1; pixel_y_in = 9'd1;
            in_valid = i[0];
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || flow_u !== 16'sd256 ||
                flow_v !== -16'sd128 || flow_status !== 2'b00 ||
                pixel_x_out !== 10'd777 || pixel_y_out !== 9'd444) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable: got %0d unstable cycles required 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: got out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_div;
        logic signed [15:0] u, v;
        logic [1:0] st;
        logic [9:0] ox;
        logic [8:0] oy;
        int lat;
        sum_IxIx = 100; sum_IyIy = 100; sum_IxIy = 0; sum_IxIt = 200; sum_IyIt = -100;
        pixel_x_in = 10'd600; pixel_y_in = 9'd200; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, flow_u, flow_v, flow_status, pixel_x_out, pixel_y_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid_div: got ov=%0b u=%0d v=%0d st=%0d x=%0d y=%0d required all 0",
                     out_valid, flow_u, flow_v, flow_status, pixel_x_out, pixel_y_out);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(100, 100, 0, 50, 100, 10'd21, 9'd22, u, v, st, ox, oy, lat);
        checks++;
        if (u !== 16'sd64 || v !== 16'sd128 || st !== 2'b00 || lat !== 18 ||
            ox !== 10'd21 || oy !== 9'd22) begin
            errors++;
            $display("FAIL after_reset: got u=%0d v=%0d st=%0d lat=%0d x=%0d y=%0d required 64 128 0 18 21 22",
                     u, v, st, lat, ox, oy);
        end
    endtask

    function automatic logic signed [31:0] rnd_sum();
        logic signed [31:0] r;
        r = $urandom;
        return r >>> $urandom_range(8, 31);
    endfunction

    task automatic test_random;
        logic signed [31:0] a, d, b, c, e;
        logic signed [15:0] u, v, eu, ev;
        logic [1:0] st, est;
        logic [9:0] ox, x;
        logic [8:0] oy, y;
        int lat, elat;
        for (int i = 0; i < 40; i++) begin
            a = rnd_sum(); d = rnd_sum(); b = rnd_sum(); c = rnd_sum(); e = rnd_sum();
            if (i % 3 == 0) b = b >>> 6;
            if (i % 8 == 7) begin
                a = $urandom_range(0, 40); d = $urandom_range(0, 40); b = 0;
            end
            x = 10'($urandom); y = 9'($urandom);
            model(a, d, b, c, e, eu, ev, est, elat);
            run_txn(a, d, b, c, e, x, y, u, v, st, ox, oy, lat);
            checks++;
            if (u !== eu || v !== ev || st !== est || lat !== elat || ox !== x || oy !== y) begin
                errors++;
                $display("FAIL random_%0d: got u=%0d v=%0d st=%0d lat=%0d x=%0d y=%0d required %0d %0d %0d %0d %0d %0d",
                         i, u, v, st, lat, ox, oy, eu, ev, est, elat, x, y);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_back_to_back;
        int t1, t2, g;
        logic signed [15:0] eu, ev;
        logic [1:0] est;
        int elat;
        out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        sum_IxIx = 100; sum_IyIy = 100; sum_IxIy = 0; sum_IxIt = 200; sum_IyIt = -100;
        pixel_x_in = 10'd31; pixel_y_in = 9'd32; in_valid = 1'b1;
        @(posedge clk); #1;
        t1 = cyc;
        sum_IxIx = 300; sum_IyIy = 200; sum_IxIy = 50; sum_IxIt = -700; sum_IyIt = 900;
        pixel_x_in = 10'd41; pixel_y_in = 9'd42;
        g = 0;
        while (!out_valid && g < 200) begin
            @(posedge clk); #1; g++;
        end
        checks++;
        if (flow_u !== 16'sd256 || flow_v !== -16'sd128 || pixel_x_out !== 10'd31) begin
            errors++;
            $display("FAIL b2b_first: got u=%0d v=%0d x=%0d required 256 -128 31", flow_u, flow_v, pixel_x_out);
        end
        g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        t2 = cyc;
        in_valid = 1'b0;
        checks++;
        if (t2 - t1 !== 20) begin
            errors++;
            $display("FAIL b2b_interval: got %0d required 20", t2 - t1);
        end
        model(300, 200, 50, -700, 900, eu, ev, est, elat);
        g = 0;
        while (!out_valid && g < 200) begin
            @(posedge clk); #1; g++;
        end
        checks++;
        if (flow_u !== eu || flow_v !== ev || flow_status !== est ||
            pixel_x_out !== 10'd41 || pixel_y_out !== 9'd42) begin
            errors++;
            $display("FAIL b2b_second: got u=%0d v=%0d st=%0d x=%0d y=%0d required %0d %0d %0d 41 42",
                     flow_u, flow_v, flow_status, pixel_x_out, pixel_y_out, eu, ev, est);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_threshold();
        test_backpressure();
        test_reset_mid_div();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
